// File: rtl/moving_sum_multi_pkg.sv
// Shared widths and lane helpers for the moving-sum family.
// Lanes are packed MSB-first: lane 0 occupies the top bits.
package moving_sum_multi_pkg;

  localparam int BUS_W  = 1024;
  localparam int LANE_W = 64;

  function automatic int lw_of(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int ow_of(
    input int width,
    input int max_len
  );
    return width + lw_of(max_len);
  endfunction

  // Extract w bits starting at lsb and sign-extend to LANE_W.
  function automatic logic [LANE_W-1:0] lane_sext(
    input logic [BUS_W-1:0] bus,
    input int               lsb,
    input int               w
  );
    logic [BUS_W-1:0]  s;
    logic [LANE_W-1:0] v;
    logic [LANE_W-1:0] m;
    logic              sgn;
    s   = bus >> lsb;
    v   = s[LANE_W-1:0];
    sgn = |(s & (BUS_W'(1) << (w - 1)));
    m   = {LANE_W{1'b1}} << w;
    return sgn ? (v | m) : (v & ~m);
  endfunction

endpackage

// File: rtl/moving_sum_multi_if.sv
// AXI-Stream input and output channels of the moving sum.
// The master drives samples in and takes sums out.
interface moving_sum_multi_if #(
  parameter int DIW = 32,
  parameter int DOW = 52
);

  logic [DIW-1:0] i_tdata;
  logic           i_tlast;
  logic           i_tvalid;
  logic           i_tready;
  logic [DOW-1:0] o_tdata;
  logic           o_tlast;
  logic           o_tvalid;
  logic           o_tready;

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

endinterface

// File: rtl/moving_sum_ring.sv
// History ring for the moving sum: read-first port, wraps at i_len,
// owns the write pointer, fill count and registered full flag.
module moving_sum_ring
  import moving_sum_multi_pkg::*;
#(
  parameter  int DW      = 32,
  parameter  int MAX_LEN = 1023,
  localparam int LW      = lw_of(MAX_LEN),
  localparam int DEPTH   = 1 << LW
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_we,
  input  logic [LW-1:0] i_len,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_full
);

  // Depth rounded to a power of two so wp indexes it exactly.
  logic [DW-1:0] r_mem [DEPTH];
  logic [LW-1:0] r_wp;
  logic [LW-1:0] r_fill;
  logic          r_full;
  logic          w_active;
  logic [LW-1:0] w_wp_nxt;
  logic [LW-1:0] w_fill_nxt;

  assign w_active = i_we && (i_len != '0);

  assign w_wp_nxt = (r_wp == i_len - LW'(1))
                  ? '0 : r_wp + LW'(1);

  assign w_fill_nxt = (r_fill == i_len)
                    ? r_fill : r_fill + LW'(1);

  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_wp   <= '0;
      r_fill <= '0;
      r_full <= 1'b0;
    end else if (w_active) begin
      r_wp   <= w_wp_nxt;
      r_fill <= w_fill_nxt;
      r_full <= (w_fill_nxt == i_len);
    end
  end

  always_ff @(posedge clk) begin
    if (w_active) begin
      r_mem[r_wp] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_wp];
  assign o_full  = r_full;

endmodule

// File: rtl/moving_sum_multi.sv
// Multi-lane moving sum over the last L accepted samples,
// with latched length, optional tlast restart and full flag.
module moving_sum_multi
  import moving_sum_multi_pkg::*;
#(
  parameter  int NUM_CH         = 2,
  parameter  int WIDTH          = 16,
  parameter  int MAX_LEN        = 1023,
  parameter  int RESET_ON_TLAST = 0,
  localparam int LW             = lw_of(MAX_LEN),
  localparam int OW             = ow_of(WIDTH, MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [LW-1:0] len,
  moving_sum_multi_if.slave axis,
  output logic          o_full
);

  localparam int DW = NUM_CH * WIDTH;

  logic                 w_rst;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_flush;
  logic                 w_len_zero;
  logic                 w_ring_full;
  logic [DW-1:0]        w_x;
  logic [DW-1:0]        w_old;
  logic [LW-1:0]        r_len;
  logic signed [OW-1:0] r_acc [NUM_CH];
  logic signed [OW-1:0] w_xs  [NUM_CH];
  logic signed [OW-1:0] w_os  [NUM_CH];
  logic signed [OW-1:0] w_nxt [NUM_CH];
  logic [NUM_CH*OW-1:0] w_nxt_bus;
  logic [NUM_CH*OW-1:0] r_data;
  logic                 r_vld;
  logic                 r_last;

  assign w_rst    = reset | clear;
  assign w_x      = axis.i_tdata;
  assign w_ready  = !w_rst && (!r_vld || axis.o_tready);
  assign w_accept = axis.i_tvalid && w_ready;

  // The tlast beat still reports the full window, then state zeroes.
  assign w_flush = (RESET_ON_TLAST != 0)
                && w_accept && axis.i_tlast;

  assign w_len_zero = (r_len == '0);

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_len <= (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
    end
  end

  moving_sum_ring #(
    .DW      (DW),
    .MAX_LEN (MAX_LEN)
  ) u_ring (
    .clk     (clk),
    .i_rst   (w_rst),
    .i_flush (w_flush),
    .i_we    (w_accept),
    .i_len   (r_len),
    .i_wdata (w_x),
    .o_rdata (w_old),
    .o_full  (w_ring_full)
  );

  always_comb begin
    w_nxt_bus = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_xs[k] = OW'(lane_sext(BUS_W'(w_x),
                  (NUM_CH - 1 - k) * WIDTH, WIDTH));
      w_os[k] = w_ring_full
              ? OW'(lane_sext(BUS_W'(w_old),
                  (NUM_CH - 1 - k) * WIDTH, WIDTH))
              : '0;
      w_nxt[k] = w_len_zero ? '0
               : r_acc[k] + w_xs[k] - w_os[k];
      w_nxt_bus[(NUM_CH-1-k)*OW +: OW] = w_nxt[k];
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst || w_flush) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_acc[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_acc[k] <= w_nxt[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_vld  <= 1'b0;
      r_last <= 1'b0;
      r_data <= '0;
    end else if (w_accept) begin
      r_vld  <= 1'b1;
      r_last <= axis.i_tlast;
      r_data <= w_nxt_bus;
    end else if (axis.o_tready) begin
      r_vld  <= 1'b0;
    end
  end

  assign axis.i_tready = w_ready;
  assign axis.o_tvalid = r_vld;
  assign axis.o_tlast  = r_last;
  assign axis.o_tdata  = r_data;
  assign o_full        = w_ring_full;

endmodule

// File: tb/tb_moving_sum_multi.sv
// Randomised bench for moving_sum_multi against a queue-based
// window model; one DUT plain, one with tlast restart.
module tb_moving_sum_multi;

  localparam int NC = 2;
  localparam int W  = 16;
  localparam int ML = 7;
  localparam int LW = 3;
  localparam int OW = 19;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [LW-1:0] len;
  logic          full_a;
  logic          full_b;

  moving_sum_multi_if #(.DIW(NC*W), .DOW(NC*OW)) ifa ();
  moving_sum_multi_if #(.DIW(NC*W), .DOW(NC*OW)) ifb ();

  always #5 clk = ~clk;

  moving_sum_multi #(
    .NUM_CH(NC), .WIDTH(W), .MAX_LEN(ML), .RESET_ON_TLAST(0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .clear(clear), .len(len),
    .axis(ifa.slave), .o_full(full_a)
  );

  moving_sum_multi #(
    .NUM_CH(NC), .WIDTH(W), .MAX_LEN(ML), .RESET_ON_TLAST(1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .clear(clear), .len(len),
    .axis(ifb.slave), .o_full(full_b)
  );

  logic [NC*OW-1:0] od [2];
  logic             ov [2];
  logic             ol [2];
  logic             ordy [2];
  logic             ofl [2];

  assign od[0]   = ifa.o_tdata;
  assign od[1]   = ifb.o_tdata;
  assign ov[0]   = ifa.o_tvalid;
  assign ov[1]   = ifb.o_tvalid;
  assign ol[0]   = ifa.o_tlast;
  assign ol[1]   = ifb.o_tlast;
  assign ordy[0] = ifa.i_tready;
  assign ordy[1] = ifb.i_tready;
  assign ofl[0]  = full_a;
  assign ofl[1]  = full_b;

  int n_chk  = 0;
  int n_fail = 0;
  int mlen;
  int len_drv;

  int               h0 [2][$];
  int               h1 [2][$];
  longint           e0 [2][$];
  longint           e1 [2][$];
  bit               el [2][$];
  bit               mfull [2];
  bit               stall [2];
  logic [NC*OW-1:0] held [2];

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset(input int ln);
    mlen = (ln > ML) ? ML : ln;
    for (int d = 0; d < 2; d++) begin
      h0[d].delete();
      h1[d].delete();
      e0[d].delete();
      e1[d].delete();
      el[d].delete();
      mfull[d] = 1'b0;
      stall[d] = 1'b0;
    end
  endtask

  // Window sum = sum of the last mlen accepted samples since restart.
  task automatic m_accept(input int a, input int b, input bit last);
    longint s0;
    longint s1;
    for (int d = 0; d < 2; d++) begin
      s0 = 0;
      s1 = 0;
      if (mlen != 0) begin
        h0[d].push_back(a);
        h1[d].push_back(b);
        if (h0[d].size() > mlen) begin
          void'(h0[d].pop_front());
          void'(h1[d].pop_front());
        end
        for (int i = 0; i < h0[d].size(); i++) begin
          s0 += h0[d][i];
          s1 += h1[d][i];
        end
      end
      e0[d].push_back(s0);
      e1[d].push_back(s1);
      el[d].push_back(last);
      mfull[d] = (mlen != 0) && (h0[d].size() == mlen);
      if (d == 1 && last) begin
        h0[d].delete();
        h1[d].delete();
        mfull[d] = 1'b0;
      end
    end
  endtask

  task automatic drive(input bit v, input int a, input int b,
                       input bit last, input bit rdy);
    ifa.i_tvalid = v;
    ifa.i_tdata  = {16'(a), 16'(b)};
    ifa.i_tlast  = last;
    ifa.o_tready = rdy;
    ifb.i_tvalid = v;
    ifb.i_tdata  = {16'(a), 16'(b)};
    ifb.i_tlast  = last;
    ifb.o_tready = rdy;
  endtask

  task automatic tick(input bit v, input int a, input int b,
                      input bit last, input bit clr, input int ln,
                      input bit rdy, output bit acc);
    bit     ev;
    bit     er;
    longint g0;
    longint g1;
    @(negedge clk);
    reset = 1'b0;
    clear = clr;
    len   = LW'(ln);
    drive(v, a, b, last, rdy);
    #1;
    acc = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ev = (e0[d].size() != 0);
      er = !clr && (!ev || rdy);
      chk("o_tvalid", longint'(ov[d]), longint'(ev));
      chk("i_tready", longint'(ordy[d]), longint'(er));
      if (stall[d]) begin
        chk("hold", longint'(od[d]), longint'(held[d]));
      end
      if (ev && rdy) begin
        g0 = longint'($signed(od[d][2*OW-1:OW]));
        g1 = longint'($signed(od[d][OW-1:0]));
        chk("lane0", g0, e0[d].pop_front());
        chk("lane1", g1, e1[d].pop_front());
        chk("o_tlast", longint'(ol[d]),
            longint'(el[d].pop_front()));
      end
      stall[d] = ev && !rdy && !clr;
      held[d]  = od[d];
      if (d == 0) acc = v && er;
    end
    if (acc) m_accept(a, b, last);
    if (clr) m_reset(ln);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("o_full", longint'(ofl[d]), longint'(mfull[d]));
    end
  endtask

  task automatic do_reset(input int ln);
    @(negedge clk);
    reset = 1'b1;
    clear = 1'b0;
    len   = LW'(ln);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    m_reset(ln);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_tvalid", longint'(ov[d]), 0);
      chk("rst_tdata", longint'(od[d]), 0);
      chk("rst_tlast", longint'(ol[d]), 0);
      chk("rst_full", longint'(ofl[d]), 0);
      chk("rst_tready", longint'(ordy[d]), 1);
    end
  endtask

  task automatic do_clear(input int ln);
    bit acc;
    tick(1'b1, 99, 99, 1'b0, 1'b1, ln, 1'b1, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(1'b0, 0, 0, 1'b0, 1'b0, len_drv, 1'b1, acc);
  endtask

  task automatic send(input int a, input int b, input bit last,
                      input bit bp);
    bit acc;
    bit r;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      r = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
      tick(1'b1, a, b, last, 1'b0, len_drv, r, acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    int a;
    int b;
    reset   = 1'b1;
    clear   = 1'b0;
    len     = '0;
    len_drv = 4;
    drive(1'b0, 0, 0, 1'b0, 1'b1);

    do_reset(4);
    for (int i = 1; i <= 8; i++) send(i, -i, 1'b0, 1'b0);
    idle(2);

    // len moves without clear: window must stay at 4
    len_drv = 2;
    for (int i = 1; i <= 6; i++) send(3 * i, -i, 1'b0, 1'b0);
    idle(2);

    do_clear(4);
    len_drv = 4;
    for (int i = 1; i <= 5; i++) send(i, -i, 1'b0, 1'b0);
    do_clear(2);
    len_drv = 2;
    for (int i = 6; i <= 8; i++) send(i, -i, 1'b0, 1'b0);
    idle(2);

    do_clear(7);
    len_drv = 7;
    repeat (10) send(32767, -32768, 1'b0, 1'b0);
    idle(2);

    do_clear(0);
    len_drv = 0;
    for (int i = 1; i <= 8; i++) send(i, -i, 1'b0, 1'b0);
    idle(2);

    do_clear(4);
    len_drv = 4;
    for (int i = 1; i <= 8; i++) send(i, -i, 1'b0, 1'b1);
    idle(3);

    do_clear(3);
    len_drv = 3;
    repeat (2) begin
      for (int i = 1; i <= 4; i++) send(i, -i, i == 4, 1'b0);
    end
    idle(2);

    repeat (6) begin
      do_clear($urandom_range(0, 7));
      repeat (40) begin
        a = int'($signed(16'($urandom)));
        b = int'($signed(16'($urandom)));
        len_drv = $urandom_range(0, 7);
        tick($urandom_range(0, 3) != 0, a, b,
             $urandom_range(0, 7) == 0, 1'b0, len_drv,
             $urandom_range(0, 2) != 0, acc);
      end
    end
    idle(4);

    for (int d = 0; d < 2; d++) begin
      chk("drain", longint'(e0[d].size()), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
